// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and helpers for the debounce bank
//
// Purpose: channel FSM state encoding and small constant helpers used to
// size counters and index ports.
// Ports: none (package).

package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE_CHK,
    S_HIGH,
    S_FALL_CHK
  } db_state_t;

  // $clog2 that never returns less than 1, so single-value ranges still get a bit.
  function automatic int clog2_min1(input int value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced input channel with optional auto-repeat
//
// Purpose: 2FF synchroniser, debounce FSM with consecutive-cycle counter,
// registered level and one-cycle press/release/repeat pulses.
// Ports:
//   clk, n_reset  clock, asynchronous active-low reset
//   btn           raw asynchronous input
//   level         debounced level
//   press, rel    registered one-cycle pulses on accepted rise / fall
//   rpt           registered one-cycle auto-repeat pulse
//   press_next    combinational: press will be registered at this edge

module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES     = 540000,
  parameter int REPEAT_EN     = 0,
  parameter int HOLD_CYCLES   = 13500000,
  parameter int REPEAT_CYCLES = 2700000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt,
  output logic press_next
);

  localparam int CNT_W = clog2_min1(max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             sync_a, sync_b;
  db_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
  logic             rep_phase, rep_phase_n;
  logic             rel_next, rpt_next;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      state     <= S_LOW;
      cnt       <= '0;
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
      level     <= 1'b0;
      press     <= 1'b0;
      rel       <= 1'b0;
      rpt       <= 1'b0;
    end else begin
      sync_a    <= btn;
      sync_b    <= sync_a;
      state     <= state_n;
      cnt       <= cnt_n;
      rep_cnt   <= rep_cnt_n;
      rep_phase <= rep_phase_n;
      press     <= press_next;
      rel       <= rel_next;
      rpt       <= rpt_next;
      if (press_next) begin
        level <= 1'b1;
      end else if (rel_next) begin
        level <= 1'b0;
      end
    end
  end

  // Debounce FSM: a change is accepted after DB_CYCLES consecutive synced
  // cycles at the new level; any return to the old level restarts from zero.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    press_next = 1'b0;
    rel_next   = 1'b0;
    case (state)
      S_LOW: begin
        if (sync_b) begin
          if (DB_CYCLES == 1) begin
            state_n    = S_HIGH;
            cnt_n      = '0;
            press_next = 1'b1;
          end else begin
            state_n = S_RISE_CHK;
            cnt_n   = CNT_W'(1);
          end
        end else begin
          cnt_n = '0;
        end
      end
      S_RISE_CHK: begin
        if (!sync_b) begin
          state_n = S_LOW;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n    = S_HIGH;
          cnt_n      = '0;
          press_next = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync_b) begin
          if (DB_CYCLES == 1) begin
            state_n  = S_LOW;
            cnt_n    = '0;
            rel_next = 1'b1;
          end else begin
            state_n = S_FALL_CHK;
            cnt_n   = CNT_W'(1);
          end
        end else begin
          cnt_n = '0;
        end
      end
      S_FALL_CHK: begin
        if (sync_b) begin
          state_n = S_HIGH;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n  = S_LOW;
          cnt_n    = '0;
          rel_next = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = S_LOW;
        cnt_n   = '0;
      end
    endcase
  end

  // Repeat timer runs from the accepted press through S_FALL_CHK; a bounce
  // back to S_HIGH keeps the original cadence. It is silenced on the edge
  // that releases, so release and repeat never share a cycle.
  always_comb begin
    rep_cnt_n   = rep_cnt;
    rep_phase_n = rep_phase;
    rpt_next    = 1'b0;
    if (REPEAT_EN == 0 || press_next || state_n == S_LOW ||
        !(state == S_HIGH || state == S_FALL_CHK)) begin
      rep_cnt_n   = '0;
      rep_phase_n = 1'b0;
    end else if (rep_cnt == (rep_phase ? REP_LAST : HOLD_LAST)) begin
      rpt_next    = 1'b1;
      rep_cnt_n   = '0;
      rep_phase_n = 1'b1;
    end else begin
      rep_cnt_n = rep_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel debouncer with first-press key capture
//
// Purpose: N_CH debounce channels plus capture of the lowest-index accepted
// press together with the side bus, held until that channel releases.
// Ports:
//   clk, n_reset  clock, asynchronous active-low reset
//   btn_i         raw button inputs
//   cap_i         side bus sampled on capture
//   level_o, press_o, release_o, repeat_o  per-channel outputs
//   key_valid_o, key_ch_o, key_cap_o       captured key

module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DB_CYCLES     = 540000,
  parameter int REPEAT_EN     = 0,
  parameter int HOLD_CYCLES   = 13500000,
  parameter int REPEAT_CYCLES = 2700000,
  parameter int CAP_W         = 4
) (
  input  logic                        clk,
  input  logic                        n_reset,
  input  logic [N_CH-1:0]             btn_i,
  input  logic [CAP_W-1:0]            cap_i,
  output logic [N_CH-1:0]             level_o,
  output logic [N_CH-1:0]             press_o,
  output logic [N_CH-1:0]             release_o,
  output logic [N_CH-1:0]             repeat_o,
  output logic                        key_valid_o,
  output logic [clog2_min1(N_CH)-1:0] key_ch_o,
  output logic [CAP_W-1:0]            key_cap_o
);

  localparam int CH_W = clog2_min1(N_CH);

  logic [N_CH-1:0] press_next;
  logic            win_any;
  logic [CH_W-1:0] win_ch;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_EN    (REPEAT_EN),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk       (clk),
      .n_reset   (n_reset),
      .btn       (btn_i[i]),
      .level     (level_o[i]),
      .press     (press_o[i]),
      .rel       (release_o[i]),
      .rpt       (repeat_o[i]),
      .press_next(press_next[i])
    );
  end

  // Scan downward so the lowest pressed index is the last one written.
  always_comb begin
    win_any = |press_next;
    win_ch  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (press_next[i]) begin
        win_ch = CH_W'(i);
      end
    end
  end

  // Capture happens on the edge that registers press_o; the clearing release
  // takes priority over any press arriving on the same edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      key_valid_o <= 1'b0;
      key_ch_o    <= '0;
      key_cap_o   <= '0;
    end else if (key_valid_o && release_o[key_ch_o]) begin
      key_valid_o <= 1'b0;
      key_ch_o    <= '0;
      key_cap_o   <= '0;
    end else if (!key_valid_o && win_any) begin
      key_valid_o <= 1'b1;
      key_ch_o    <= win_ch;
      key_cap_o   <= cap_i;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - self-checking bench for debounce_bank

module tb_debounce_bank;

  localparam int N_CH = 4;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [3:0] btn = '0;
  logic [3:0] cap = '0;
  logic [3:0] level_o, press_o, release_o, repeat_o;
  logic       key_valid_o;
  logic [1:0] key_ch_o;
  logic [3:0] key_cap_o;

  debounce_bank #(
    .N_CH(N_CH), .DB_CYCLES(DB), .REPEAT_EN(1),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CAP_W(4)
  ) dut (
    .clk(clk), .n_reset(n_reset), .btn_i(btn), .cap_i(cap),
    .level_o(level_o), .press_o(press_o), .release_o(release_o), .repeat_o(repeat_o),
    .key_valid_o(key_valid_o), .key_ch_o(key_ch_o), .key_cap_o(key_cap_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int edge_t = 0;

  // Reference model: raw input delayed two edges, then a run-length count of
  // cycles the synced value disagrees with the accepted level.
  logic [3:0] m_s1, m_s2, m_level, m_press, m_rel, m_rpt;
  int         m_run[4];
  int         m_tpress[4];
  logic       m_kv;
  logic [1:0] m_kch;
  logic [3:0] m_kcap;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] cap;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic       kv;
    logic [1:0] kch;
    logic [3:0] kcap;
  } vec_t;

  vec_t tbl[14];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_rpt = '0;
    m_kv = 1'b0; m_kch = '0; m_kcap = '0;
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0;
      m_tpress[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] rel_prev;
    logic [3:0] s_used;
    int d;
    rel_prev = m_rel;
    s_used = m_s2;
    m_s2 = m_s1;
    m_s1 = btn;
    m_press = '0; m_rel = '0; m_rpt = '0;
    for (int i = 0; i < 4; i++) begin
      if (s_used[i] != m_level[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == DB) begin
        m_run[i] = 0;
        if (m_level[i]) m_rel[i] = 1'b1;
        else begin
          m_press[i] = 1'b1;
          m_tpress[i] = edge_t;
        end
      end
      if (m_level[i] && !m_rel[i]) begin
        d = edge_t - m_tpress[i];
        if (d >= HOLD && ((d - HOLD) % REP) == 0) m_rpt[i] = 1'b1;
      end
      m_level[i] = m_level[i] ^ (m_press[i] | m_rel[i]);
    end
    if (m_kv && rel_prev[m_kch]) begin
      m_kv = 1'b0; m_kch = '0; m_kcap = '0;
    end else if (!m_kv && m_press != 0) begin
      m_kv = 1'b1;
      m_kcap = cap;
      for (int i = 3; i >= 0; i--) if (m_press[i]) m_kch = 2'(i);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_t);
    end
  endtask

  task automatic compare_model();
    check("model", {9'd0, level_o, press_o, release_o, repeat_o, key_valid_o, key_ch_o, key_cap_o},
          {9'd0, m_level, m_press, m_rel, m_rpt, m_kv, m_kch, m_kcap});
  endtask

  task automatic step();
    @(posedge clk);
    edge_t++;
    if (n_reset) model_edge();
    #1;
    compare_model();
  endtask

  int first_rep, rep_total, after_rel, rel_cnt, prs_cnt, got;
  logic rel_seen, found;

  initial begin
    // rows: btn, cap, level, press, key_valid, key_ch, key_cap (after each edge)
    for (int j = 0; j < 5; j++) tbl[j] = '{4'b0001, 4'b1011, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000};
    tbl[5] = '{4'b0001, 4'b1011, 4'b0001, 4'b0001, 1'b1, 2'd0, 4'b1011};
    for (int j = 6; j < 9; j++)  tbl[j] = '{4'b0011, 4'b0110, 4'b0001, 4'b0000, 1'b1, 2'd0, 4'b1011};
    for (int j = 9; j < 14; j++) tbl[j] = '{4'b0001, 4'b0110, 4'b0001, 4'b0000, 1'b1, 2'd0, 4'b1011};

    model_reset();
    #1;
    check("reset_state", {9'd0, level_o, press_o, release_o, repeat_o, key_valid_o, key_ch_o, key_cap_o}, 32'd0);
    step(); step();
    n_reset = 1'b1;
    edge_t = 0;

    // Clean press ch0, capture, ch1 glitch rejection
    for (int j = 0; j < 14; j++) begin
      btn = tbl[j].btn;
      cap = tbl[j].cap;
      step();
      check($sformatf("tbl%0d_level", j), {28'd0, level_o}, {28'd0, tbl[j].lvl});
      check($sformatf("tbl%0d_press", j), {28'd0, press_o}, {28'd0, tbl[j].prs});
      check($sformatf("tbl%0d_key", j), {25'd0, key_valid_o, key_ch_o, key_cap_o},
            {25'd0, tbl[j].kv, tbl[j].kch, tbl[j].kcap});
    end

    // Auto-repeat while held, then release
    first_rep = -1; rep_total = 0; after_rel = 0; rel_seen = 1'b0;
    for (int k = 15; k <= 31; k++) begin
      step();
      if (repeat_o[0]) begin
        rep_total++;
        if (first_rep < 0) first_rep = edge_t;
      end
    end
    btn = 4'b0000;
    for (int k = 0; k < 15; k++) begin
      step();
      if (release_o[0]) rel_seen = 1'b1;
      else if (rel_seen && repeat_o[0]) after_rel++;
      if (!rel_seen && repeat_o[0]) rep_total++;
    end
    check("first_repeat_edge", first_rep, 6 + HOLD);
    check("repeat_count", rep_total, 7);
    check("release_seen", {31'd0, rel_seen}, 1);
    check("repeat_after_release", after_rel, 0);
    check("key_cleared", {31'd0, key_valid_o}, 0);

    // Simultaneous press ch2+ch3
    btn = 4'b1100; cap = 4'b0101; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (press_o != 0) found = 1'b1;
    end
    check("simul_press", {28'd0, press_o}, 32'b1100);
    check("simul_kch", {30'd0, key_ch_o}, 2);
    check("simul_kcap", {28'd0, key_cap_o}, 4'b0101);
    btn = 4'b0100;
    for (int k = 0; k < 10; k++) step();
    check("other_release_kv", {31'd0, key_valid_o}, 1);
    btn = 4'b0000;
    for (int k = 0; k < 10; k++) step();
    check("own_release_kv", {31'd0, key_valid_o}, 0);
    check("own_release_kcap", {28'd0, key_cap_o}, 0);

    // Bouncy release on ch0
    btn = 4'b0001;
    for (int k = 0; k < 8; k++) step();
    rel_cnt = 0; prs_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      btn = (k < 4) ? {3'b000, k[0]} : 4'b0000;
      step();
      if (release_o[0]) rel_cnt++;
      if (press_o[0]) prs_cnt++;
    end
    check("bouncy_release_count", rel_cnt, 1);
    check("bouncy_press_count", prs_cnt, 0);

    // Reset while ch1 held and captured
    btn = 4'b0010; cap = 4'b1110;
    for (int k = 0; k < 10; k++) step();
    check("pre_reset_key", {29'd0, key_valid_o, key_ch_o}, {29'd0, 1'b1, 2'd1});
    #2;
    n_reset = 1'b0;
    #1;
    check("async_reset_outputs", {9'd0, level_o, press_o, release_o, repeat_o, key_valid_o, key_ch_o, key_cap_o}, 32'd0);
    model_reset();
    step(); step();
    n_reset = 1'b1;
    edge_t = 0;
    got = -1;
    for (int k = 1; k <= 15 && got < 0; k++) begin
      step();
      if (press_o[1]) got = k;
    end
    check("post_reset_press_edge", got, DB + 2);
    check("post_reset_key", {25'd0, key_valid_o, key_ch_o, key_cap_o}, {25'd0, 1'b1, 2'd1, 4'b1110});

    // Random traffic against the model
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(11) == 0) btn[i] = ~btn[i];
      cap = 4'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
